// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
// Build option: COUNTDOWN_BLINK_EN enables the expiry display blink in the top level.
package countdown_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam int unsigned SEC_ONES_MAX_DEF = 9;
  localparam int unsigned SEC_TENS_MAX_DEF = 5;
  localparam int unsigned MIN_ONES_MAX_DEF = 9;
  localparam int unsigned MIN_TENS_MAX_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXP
  } state_e;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: clamped load, decrement with borrow in, wrap to MAX with borrow out.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] value,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MaxV = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (dec) begin
      value_d = (value_q == '0) ? MaxV : value_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign borrow_out = dec && (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: four chained BCD digits, control FSM, registered status outputs.
// Build option: COUNTDOWN_BLINK_EN makes BLANK toggle on each TICK while expired.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned SEC_ONES_MAX = SEC_ONES_MAX_DEF,
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int unsigned MIN_ONES_MAX = MIN_ONES_MAX_DEF,
  parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 TICK,
  input  logic                 LOAD,
  input  logic [4*DIGIT_W-1:0] LOAD_VAL,
  input  logic                 START,
  input  logic                 STOP,
  output logic [DIGIT_W-1:0]   DIGIT0,
  output logic [DIGIT_W-1:0]   DIGIT1,
  output logic [DIGIT_W-1:0]   DIGIT2,
  output logic [DIGIT_W-1:0]   DIGIT3,
  output logic                 RUNNING,
  output logic                 DONE,
  output logic                 EXPIRED,
  output logic                 BLANK
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   running_q, expired_q;
  logic   dec;
  logic   count_zero, count_one;
  logic [3:0] borrow;
  logic   unused_borrow;

  // Higher-priority pulses swallow a coincident TICK.
  assign dec = TICK && !LOAD && !STOP && !START && (state_q == RUN);

  assign count_zero = ({DIGIT3, DIGIT2, DIGIT1, DIGIT0} == 16'h0000);
  assign count_one  = ({DIGIT3, DIGIT2, DIGIT1, DIGIT0} == 16'h0001);

  bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load       (LOAD),
    .load_val   (LOAD_VAL[3:0]),
    .dec        (dec),
    .value      (DIGIT0),
    .borrow_out (borrow[0])
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load       (LOAD),
    .load_val   (LOAD_VAL[7:4]),
    .dec        (borrow[0]),
    .value      (DIGIT1),
    .borrow_out (borrow[1])
  );

  bcd_down_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load       (LOAD),
    .load_val   (LOAD_VAL[11:8]),
    .dec        (borrow[1]),
    .value      (DIGIT2),
    .borrow_out (borrow[2])
  );

  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load       (LOAD),
    .load_val   (LOAD_VAL[15:12]),
    .dec        (borrow[2]),
    .value      (DIGIT3),
    .borrow_out (borrow[3])
  );

  // RUN is never entered at zero, so the top digit never borrows.
  assign unused_borrow = borrow[3];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (LOAD) begin
      state_d = IDLE;
    end else if (STOP) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (START) begin
      if ((state_q == IDLE || state_q == PAUSE) && !count_zero) state_d = RUN;
    end else if (dec && count_one) begin
      state_d = EXP;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXP);
    end
  end

  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign EXPIRED = expired_q;

`ifdef COUNTDOWN_BLINK_EN
  logic blank_q, blank_d;

  // The expiry edge itself leaves BLANK low; the first TICK in EXP raises it.
  always_comb begin
    blank_d = blank_q;
    if (LOAD || state_d != EXP) begin
      blank_d = 1'b0;
    end else if (TICK && state_q == EXP) begin
      blank_d = ~blank_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign BLANK = blank_q;
`else
  assign BLANK = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: table-driven vectors plus hand-written long sequences.
module tb_countdown_timer;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        TICK = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] LOAD_VAL = 16'h0000;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [3:0]  DIGIT0, DIGIT1, DIGIT2, DIGIT3;
  logic        RUNNING, DONE, EXPIRED, BLANK;
  logic [15:0] cnt;

  assign cnt = {DIGIT3, DIGIT2, DIGIT1, DIGIT0};

  countdown_timer dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .TICK     (TICK),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .START    (START),
    .STOP     (STOP),
    .DIGIT0   (DIGIT0),
    .DIGIT1   (DIGIT1),
    .DIGIT2   (DIGIT2),
    .DIGIT3   (DIGIT3),
    .RUNNING  (RUNNING),
    .DONE     (DONE),
    .EXPIRED  (EXPIRED),
    .BLANK    (BLANK)
  );

  always #10 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the negedge; outputs are sampled at the following negedge.
  task automatic drive(input logic ld, input logic [15:0] v, input logic st, input logic sp,
                       input logic tk);
    LOAD = ld; LOAD_VAL = v; START = st; STOP = sp; TICK = tk;
    @(posedge CLK);
    @(negedge CLK);
    LOAD = 1'b0; START = 1'b0; STOP = 1'b0; TICK = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] c, input logic run,
                           input logic dn, input logic ex, input logic bl);
    check({tag, " count"}, 32'(cnt), 32'(c));
    check({tag, " running"}, 32'(RUNNING), 32'(run));
    check({tag, " done"}, 32'(DONE), 32'(dn));
    check({tag, " expired"}, 32'(EXPIRED), 32'(ex));
    check({tag, " blank"}, 32'(BLANK), 32'(bl));
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        st;
    logic        sp;
    logic        tk;
    logic [15:0] cnt;
    logic        run;
    logic        dn;
    logic        ex;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input logic [15:0] val, input logic st, input logic sp,
                     input logic tk, input logic [15:0] c, input logic run, input logic dn,
                     input logic ex);
    vec_t v;
    v.ld = ld; v.val = val; v.st = st; v.sp = sp; v.tk = tk;
    v.cnt = c; v.run = run; v.dn = dn; v.ex = ex;
    tbl.push_back(v);
  endtask

  initial begin
    int early_done;

    // Clamping, pause, resume
    add(1, 16'h6A7C, 0, 0, 0, 16'h5959, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h5959, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h5958, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 16'h5958, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h5957, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h5956, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 16'h5956, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 0, 1, 16'h5956, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h5956, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h5955, 1, 0, 0);
    // Zero load: START refused
    add(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0);
    // START with TICK, STOP with TICK, expiry
    add(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 1, 16'h0002, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 1, 16'h0001, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h0001, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1);
    add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1);
    // LOAD clears expiry; LOAD with TICK mid-run is not decremented
    add(1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h0005, 1, 0, 0);
    add(1, 16'h0030, 0, 0, 1, 16'h0030, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 16'h0030, 0, 0, 0);

    // Reset held for two cycles
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all("reset", 16'h0000, 0, 0, 0, 0);
    RESET_N = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].sp, tbl[i].tk);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].run, tbl[i].dn, tbl[i].ex, 1'b0);
    end

    // 10:00 with full borrow chain, then 599 more ticks to expiry
    drive(1, 16'h1000, 0, 0, 0);
    drive(0, 16'h0000, 1, 0, 0);
    drive(0, 16'h0000, 0, 0, 1);
    check_all("borrow 10:00", 16'h0959, 1, 0, 0, 0);
    early_done = 0;
    for (int i = 0; i < 598; i++) begin
      drive(0, 16'h0000, 0, 0, 1);
      if (DONE || EXPIRED || !RUNNING) early_done++;
      if (i == 58) check("count at 09:00", 32'(cnt), 32'h0900);
    end
    check("early expiry", 32'(early_done), 32'd0);
    check("count at 00:01", 32'(cnt), 32'h0001);
    drive(0, 16'h0000, 0, 0, 1);
    check_all("expire", 16'h0000, 0, 1, 1, 0);
    drive(0, 16'h0000, 0, 0, 0);
    check_all("after expire", 16'h0000, 0, 0, 1, 0);

    // Blink while expired
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'h0000, 0, 0, 1);
      check_all($sformatf("blink%0d", k), 16'h0000, 0, 0, 1, BlinkEn && (k % 2 == 0));
    end
    drive(1, 16'h0100, 0, 0, 1);
    check_all("load clears blank", 16'h0100, 0, 0, 0, 0);

    // Reset mid-run
    drive(0, 16'h0000, 1, 0, 0);
    drive(0, 16'h0000, 0, 0, 1);
    check_all("run 00:59", 16'h0059, 1, 0, 0, 0);
    RESET_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_all("reset mid-run", 16'h0000, 0, 0, 0, 0);
    RESET_N = 1'b1;
    drive(0, 16'h0000, 1, 0, 1);
    check_all("start after reset", 16'h0000, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
